// File: rtl/simon_sequencer_if.sv
// Signal bundle between the Simon game sequencer and its neighbours:
// the LFSR random source, the button debouncers and the LED/display logic.
// Signal suffixes are named from the sequencer's point of view.
interface simon_sequencer_if;
  logic       start_i;
  logic [3:0] btn_i;
  logic       random_i;
  logic [2:0] next_random_i;
  logic       step_o;
  logic       rerun_o;
  logic       randomize_o;
  logic [3:0] led_o;
  logic [4:0] round_o;
  logic       win_o;
  logic       lose_o;

  modport slave (
    input  start_i, btn_i, random_i, next_random_i,
    output step_o, rerun_o, randomize_o, led_o, round_o, win_o, lose_o
  );

  modport master (
    output start_i, btn_i, random_i, next_random_i,
    input  step_o, rerun_o, randomize_o, led_o, round_o, win_o, lose_o
  );
endinterface

// File: rtl/simon_sequencer.sv
// Simon game controller. Seeds the LFSR while start is held, snapshots it,
// then each round rewinds to the snapshot, shows len colours on the LEDs,
// rewinds again and checks the player's presses against the same sequence.
module simon_sequencer #(
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned SHOW_CYCLES    = 25_000_000,
  parameter int unsigned GAP_CYCLES     = 12_500_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input logic              clk,
  input logic              reset,
  simon_sequencer_if.slave bus_io
);

  localparam int unsigned MaxSg    = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int unsigned MaxParam = (MaxSg > TIMEOUT_CYCLES) ? MaxSg : TIMEOUT_CYCLES;
  localparam int unsigned TimerW   = (MaxParam > 1) ? $clog2(MaxParam) : 1;

  // Timers count 0..N-1, so the last-cycle value always fits in TimerW bits.
  localparam logic [TimerW-1:0] ShowLast    = TimerW'(SHOW_CYCLES - 1);
  localparam logic [TimerW-1:0] GapLast     = TimerW'(GAP_CYCLES - 1);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [TimerW-1:0] TimerOne    = TimerW'(1);
  localparam logic [4:0]        MaxLenL     = 5'(MAX_LEN);

  typedef enum logic [3:0] {
    StIdle, StSeed, StSnap, StRewindS, StShow, StGap, StRewindI, StInput, StWin, StLose
  } state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [4:0]        idx_q, idx_d;
  logic [4:0]        len_q, len_d;
  logic [4:0]        round_q, round_d;
  logic [3:0]        led_q, led_d;
  logic              win_q, win_d;
  logic              lose_q, lose_d;

  logic [1:0] colour;
  logic [3:0] colour_led;
  logic       press_ok;
  logic [4:0] idx_inc;
  logic [4:0] len_inc;
  logic       unused_rand;

  assign colour      = {bus_io.next_random_i[0], bus_io.random_i};
  assign colour_led  = 4'b0001 << colour;
  // A correct press is exactly the one-hot code of the current colour.
  assign press_ok    = (bus_io.btn_i == colour_led);
  assign idx_inc     = (idx_q >= MaxLenL) ? MaxLenL : idx_q + 5'd1;
  assign len_inc     = (len_q >= MaxLenL) ? MaxLenL : len_q + 5'd1;
  assign unused_rand = ^bus_io.next_random_i[2:1];

  // LFSR requests are decoded straight from state so they line up with the
  // one-clock LFSR latency.
  assign bus_io.randomize_o = (state_q == StSeed);
  assign bus_io.rerun_o     = (state_q == StRewindS) || (state_q == StRewindI);
  assign bus_io.step_o      = ((state_q == StGap) && (timer_q == GapLast)) ||
                              ((state_q == StInput) && press_ok);

  assign bus_io.led_o   = led_q;
  assign bus_io.round_o = round_q;
  assign bus_io.win_o   = win_q;
  assign bus_io.lose_o  = lose_q;

  // Next-state and next-output computation for the game FSM.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    len_d   = len_q;
    led_d   = led_q;
    win_d   = win_q;
    lose_d  = lose_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.start_i) state_d = StSeed;
      end
      StSeed: begin
        if (!bus_io.start_i) begin
          state_d = StSnap;
          len_d   = 5'd1;
        end
      end
      // LFSR takes its snapshot here; rerun must wait one more cycle.
      StSnap: state_d = StRewindS;
      StRewindS: begin
        idx_d   = '0;
        timer_d = '0;
        state_d = StShow;
      end
      StShow: begin
        if (timer_q == '0) led_d = colour_led;
        if (timer_q == ShowLast) begin
          timer_d = '0;
          state_d = StGap;
        end else begin
          timer_d = timer_q + TimerOne;
        end
      end
      StGap: begin
        led_d = '0;
        if (timer_q == GapLast) begin
          timer_d = '0;
          idx_d   = idx_inc;
          state_d = (idx_inc == len_q) ? StRewindI : StShow;
        end else begin
          timer_d = timer_q + TimerOne;
        end
      end
      StRewindI: begin
        idx_d   = '0;
        timer_d = '0;
        led_d   = '0;
        state_d = StInput;
      end
      StInput: begin
        led_d = '0;
        if (bus_io.btn_i == 4'b0000) begin
          if (timer_q == TimeoutLast) begin
            state_d = StLose;
            lose_d  = 1'b1;
          end else begin
            timer_d = timer_q + TimerOne;
          end
        end else if (press_ok) begin
          timer_d = '0;
          idx_d   = idx_inc;
          if (idx_inc == len_q) begin
            if (len_q == MaxLenL) begin
              state_d = StWin;
              win_d   = 1'b1;
              led_d   = 4'b1111;
            end else begin
              len_d   = len_inc;
              state_d = StRewindS;
            end
          end
        end else begin
          state_d = StLose;
          lose_d  = 1'b1;
        end
      end
      StWin, StLose: begin
        if (bus_io.start_i) begin
          state_d = StSeed;
          win_d   = 1'b0;
          lose_d  = 1'b0;
          led_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
    round_d = (state_d == StIdle) ? 5'd0 : len_d;
  end

  // State and registered outputs; reset wins over every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      timer_q <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      round_q <= '0;
      led_q   <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      round_q <= round_d;
      led_q   <= led_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
    end
  end

endmodule
